// File: rtl/key_conditioner.sv
// ----------------------------------------------------------------------------
// key_conditioner
//
// Front-end stage for the digital lock keypad. Takes four raw push buttons,
// synchronises and debounces each one independently, then runs a small press
// FSM that accepts exactly one key at a time. It presents a clean held key
// code and single-cycle press/release strobes, and flags illegal multi-key
// presses. keyPress is also used downstream to restart the lock's timeout.
//
// Parameters
//   clockFrequency  input clock frequency in Hz
//   debounceMs      time a button must be stable before it is accepted, ms
//   keyActiveLow    1: raw button reads 0 when pressed
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   asynchronous reset, active-low
//   rawKey[3:0]    in   unsynchronised push-button inputs
//   key[3:0]       out  debounced one-hot key, held while pressed, else 0
//   keyPress       out  1-cycle strobe on each valid new press
//   keyRelease     out  1-cycle strobe when the held key is released
//   multiKeyError  out  1-cycle strobe when more than one key is active
//   busy           out  high while a key is held or while locked out
// ----------------------------------------------------------------------------
module key_conditioner #(
    parameter int clockFrequency = 50000000,
    parameter int debounceMs     = 20,
    parameter int keyActiveLow   = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rawKey,
    output logic [3:0] key,
    output logic       keyPress,
    output logic       keyRelease,
    output logic       multiKeyError,
    output logic       busy
);

    // Must come out >= 1 for the chosen parameters.
    localparam int DEBOUNCE_CYCLES = clockFrequency / 1000 * debounceMs;
    localparam int COUNT_WIDTH     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LOCKOUT = 2'd2
    } stateType;

    // Internally a pressed button is always 1, whatever the board wiring, so
    // the released/reset value of every sync and stable bit is 0.
    logic [3:0] pressedRaw;
    logic [3:0] syncFirst;
    logic [3:0] syncKey;
    logic [3:0] stableKey;
    stateType   state;

    assign pressedRaw = (keyActiveLow != 0) ? ~rawKey : rawKey;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncFirst <= 4'b0000;
            syncKey   <= 4'b0000;
        end else begin
            syncFirst <= pressedRaw;
            syncKey   <= syncFirst;
        end
    end

    // Each bit has its own counter. The counter only runs while the
    // synchronised input disagrees with the accepted value, so any glitch
    // shorter than DEBOUNCE_CYCLES restarts it from zero and is ignored.
    for (genvar i = 0; i < 4; i++) begin : gDebounce
        logic [COUNT_WIDTH-1:0] count;
        logic                   stableBit;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                count     <= '0;
                stableBit <= 1'b0;
            end else if (syncKey[i] == stableBit) begin
                count <= '0;
            end else if (count == LAST_COUNT) begin
                stableBit <= syncKey[i];
                count     <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end

        assign stableKey[i] = stableBit;
    end

    // d & (d - 1) clears the lowest set bit, so it is non-zero exactly when
    // more than one key is active.
    logic [3:0] stableMinusOne;
    logic       anyKey;
    logic       severalKeys;

    assign stableMinusOne = stableKey - 4'd1;
    assign anyKey         = (stableKey != 4'b0000);
    assign severalKeys    = ((stableKey & stableMinusOne) != 4'b0000);

    // Press FSM. All outputs are registered; strobes default low every cycle
    // so each one lasts a single clock and at most one fires per edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            key           <= 4'b0000;
            keyPress      <= 1'b0;
            keyRelease    <= 1'b0;
            multiKeyError <= 1'b0;
            busy          <= 1'b0;
        end else begin
            keyPress      <= 1'b0;
            keyRelease    <= 1'b0;
            multiKeyError <= 1'b0;

            case (state)
                IDLE: begin
                    if (severalKeys) begin
                        multiKeyError <= 1'b1;
                        key           <= 4'b0000;
                        busy          <= 1'b1;
                        state         <= LOCKOUT;
                    end else if (anyKey) begin
                        key      <= stableKey;
                        keyPress <= 1'b1;
                        busy     <= 1'b1;
                        state    <= PRESSED;
                    end
                end

                PRESSED: begin
                    if (stableKey == key) begin
                        busy <= 1'b1;
                    end else if (!anyKey) begin
                        key        <= 4'b0000;
                        keyRelease <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        // A changed or added key is treated as tampering:
                        // drop the code without a release strobe.
                        key           <= 4'b0000;
                        multiKeyError <= 1'b1;
                        busy          <= 1'b1;
                        state         <= LOCKOUT;
                    end
                end

                LOCKOUT: begin
                    key <= 4'b0000;
                    if (!anyKey) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        busy <= 1'b1;
                    end
                end

                default: begin
                    key   <= 4'b0000;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// ----------------------------------------------------------------------------
// tb_key_conditioner
//
// Self-checking bench for key_conditioner with DEBOUNCE_CYCLES = 4
// (clockFrequency = 1000, debounceMs = 4, active-low buttons). Expected strobe
// events are queued as stimulus is applied; a monitor pops and compares them
// whenever the DUT raises a strobe. Directed cycle-exact checks cover latency,
// reset behaviour and the held key code.
// ----------------------------------------------------------------------------
module tb_key_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rawKey = 4'b1111;
    logic [3:0] key;
    logic       keyPress;
    logic       keyRelease;
    logic       multiKeyError;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int pressCount = 0;
    int releaseCount = 0;

    typedef struct packed {
        logic [1:0] kind;
        logic [3:0] code;
    } keyEvent;

    localparam logic [1:0] EV_PRESS   = 2'd1;
    localparam logic [1:0] EV_RELEASE = 2'd2;
    localparam logic [1:0] EV_MULTI   = 2'd3;

    keyEvent expectedQ[$];
    keyEvent observedEvent;
    keyEvent expectedEvent;

    always #5 clock = ~clock;

    key_conditioner #(
        .clockFrequency(1000),
        .debounceMs    (4),
        .keyActiveLow  (1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .rawKey       (rawKey),
        .key          (key),
        .keyPress     (keyPress),
        .keyRelease   (keyRelease),
        .multiKeyError(multiKeyError),
        .busy         (busy)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives a new raw value just after a rising edge; that edge is edge 0
    // for the latency arithmetic.
    task automatic applyStimulus(input logic [3:0] value);
        @(posedge clock);
        #1 rawKey = value;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic expectEvent(input logic [1:0] kind, input logic [3:0] code);
        expectedQ.push_back(keyEvent'{kind: kind, code: code});
    endtask

    task automatic drainScoreboard(input string tag);
        int waited = 0;
        while (expectedQ.size() != 0 && waited < 30) begin
            @(negedge clock);
            waited++;
        end
        #1;
        checkOutput(tag, 8'(expectedQ.size()), 8'd0);
        expectedQ.delete();
        waitCycles(2);
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected event.
    always @(negedge clock) begin
        if (keyPress || keyRelease || multiKeyError) begin
            checkOutput("strobeExclusive",
                        8'({1'b0, keyPress} + {1'b0, keyRelease} + {1'b0, multiKeyError}), 8'd1);
            observedEvent.kind = keyPress ? EV_PRESS : (keyRelease ? EV_RELEASE : EV_MULTI);
            observedEvent.code = key;
            if (keyPress) pressCount++;
            if (keyRelease) releaseCount++;
            if (expectedQ.size() == 0) begin
                checkOutput("unexpectedStrobe", {2'b00, observedEvent}, 8'h00);
            end else begin
                expectedEvent = expectedQ.pop_front();
                checkOutput("scoreboardEvent", {2'b00, observedEvent}, {2'b00, expectedEvent});
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pressBase;
        int releaseBase;

        // Reset state
        @(negedge clock);
        checkOutput("resetKey", {4'b0, key}, 8'h00);
        checkOutput("resetStrobes", {5'b0, keyPress, keyRelease, multiKeyError}, 8'h00);
        checkOutput("resetBusy", {7'b0, busy}, 8'h00);
        @(posedge clock);
        #1 reset = 1'b1;
        waitCycles(5);

        // 1: key1 press latency and one-cycle strobes
        $display("[TB] step 1: single press/release latency");
        expectEvent(EV_PRESS, 4'b0010);
        applyStimulus(4'b1101);
        repeat (6) @(posedge clock);
        @(negedge clock);
        checkOutput("t1KeyBeforeEdge7", {4'b0, key}, 8'h00);
        checkOutput("t1PressBeforeEdge7", {7'b0, keyPress}, 8'h00);
        @(negedge clock);
        checkOutput("t1KeyAfterEdge7", {4'b0, key}, 8'h02);
        checkOutput("t1PressAfterEdge7", {7'b0, keyPress}, 8'h01);
        checkOutput("t1BusyHeld", {7'b0, busy}, 8'h01);
        @(negedge clock);
        checkOutput("t1PressOneCycle", {7'b0, keyPress}, 8'h00);
        checkOutput("t1KeyHeld", {4'b0, key}, 8'h02);
        expectEvent(EV_RELEASE, 4'b0000);
        applyStimulus(4'b1111);
        repeat (6) @(posedge clock);
        @(negedge clock);
        checkOutput("t1KeyBeforeRelease", {4'b0, key}, 8'h02);
        checkOutput("t1ReleaseEarly", {7'b0, keyRelease}, 8'h00);
        @(negedge clock);
        checkOutput("t1ReleaseAfterEdge7", {7'b0, keyRelease}, 8'h01);
        checkOutput("t1KeyReleased", {4'b0, key}, 8'h00);
        checkOutput("t1BusyReleased", {7'b0, busy}, 8'h00);
        drainScoreboard("t1Drain");

        // 2: bounce shorter than the debounce window
        $display("[TB] step 2: bounce rejection");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1110);
            waitCycles(1);
            applyStimulus(4'b1111);
            waitCycles(1);
        end
        waitCycles(12);
        @(negedge clock);
        checkOutput("t2KeyStaysZero", {4'b0, key}, 8'h00);
        checkOutput("t2BusyLow", {7'b0, busy}, 8'h00);
        checkOutput("t2NoEvents", 8'(expectedQ.size()), 8'd0);

        // 3: two keys on the same edge, then a normal press
        $display("[TB] step 3: simultaneous keys");
        expectEvent(EV_MULTI, 4'b0000);
        applyStimulus(4'b0110);
        drainScoreboard("t3MultiDrain");
        checkOutput("t3KeyZero", {4'b0, key}, 8'h00);
        checkOutput("t3BusyLockout", {7'b0, busy}, 8'h01);
        applyStimulus(4'b1111);
        waitCycles(10);
        @(negedge clock);
        checkOutput("t3BackToIdle", {7'b0, busy}, 8'h00);
        expectEvent(EV_PRESS, 4'b0100);
        applyStimulus(4'b1011);
        drainScoreboard("t3PressDrain");
        checkOutput("t3Key2", {4'b0, key}, 8'h04);
        expectEvent(EV_RELEASE, 4'b0000);
        applyStimulus(4'b1111);
        drainScoreboard("t3ReleaseDrain");

        // 4: extra key added while one is held
        $display("[TB] step 4: added key lockout");
        expectEvent(EV_PRESS, 4'b0100);
        applyStimulus(4'b1011);
        drainScoreboard("t4PressDrain");
        checkOutput("t4Key2Held", {4'b0, key}, 8'h04);
        expectEvent(EV_MULTI, 4'b0000);
        applyStimulus(4'b1010);
        drainScoreboard("t4MultiDrain");
        checkOutput("t4KeyDropped", {4'b0, key}, 8'h00);
        applyStimulus(4'b1110);
        waitCycles(12);
        @(negedge clock);
        checkOutput("t4StillLocked", {7'b0, busy}, 8'h01);
        checkOutput("t4NoPressInLockout", {4'b0, key}, 8'h00);
        applyStimulus(4'b1111);
        waitCycles(10);
        @(negedge clock);
        checkOutput("t4Unlocked", {7'b0, busy}, 8'h00);
        checkOutput("t4NoEvents", 8'(expectedQ.size()), 8'd0);

        // 5: reset while key3 is held
        $display("[TB] step 5: reset mid-press");
        expectEvent(EV_PRESS, 4'b1000);
        applyStimulus(4'b0111);
        drainScoreboard("t5PressDrain");
        checkOutput("t5Key3Held", {4'b0, key}, 8'h08);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("t5AsyncKeyClear", {4'b0, key}, 8'h00);
        checkOutput("t5AsyncBusyClear", {7'b0, busy}, 8'h00);
        waitCycles(3);
        expectEvent(EV_PRESS, 4'b1000);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (6) @(posedge clock);
        @(negedge clock);
        checkOutput("t5PressBeforeEdge7", {7'b0, keyPress}, 8'h00);
        @(negedge clock);
        checkOutput("t5PressAfterEdge7", {7'b0, keyPress}, 8'h01);
        checkOutput("t5KeyAfterReset", {4'b0, key}, 8'h08);
        drainScoreboard("t5RepressDrain");
        expectEvent(EV_RELEASE, 4'b0000);
        applyStimulus(4'b1111);
        drainScoreboard("t5ReleaseDrain");

        // 6: each key in turn
        $display("[TB] step 6: all keys in turn");
        pressBase   = pressCount;
        releaseBase = releaseCount;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] code;
            code = 4'b0001 << k;
            expectEvent(EV_PRESS, code);
            applyStimulus(~code);
            drainScoreboard("t6PressDrain");
            checkOutput("t6KeyCode", {4'b0, key}, {4'b0, code});
            checkOutput("t6BusyHeld", {7'b0, busy}, 8'h01);
            expectEvent(EV_RELEASE, 4'b0000);
            applyStimulus(4'b1111);
            drainScoreboard("t6ReleaseDrain");
            checkOutput("t6BusyIdle", {7'b0, busy}, 8'h00);
        end
        checkOutput("t6PressCount", 8'(pressCount - pressBase), 8'd4);
        checkOutput("t6ReleaseCount", 8'(releaseCount - releaseBase), 8'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
